// File: rtl/delay_chain_tester.sv
// delay_chain_tester
//   Built-in tester for an external registered delay chain. A run drives a
//   deterministic word stream into the chain, waits depth_p cycles for the
//   pipeline to fill, then compares len_p returned words against a second,
//   lagging copy of the same generator and counts mismatches.
//
//   Optional feature macro: DELAY_CHAIN_TESTER_LFSR_EN
//     defined   : pattern p[k] = low width_p bits of state k of a 16-bit
//                 Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1)
//     undefined : pattern p[k] = k mod 2^width_p (wrapping counter)
//
// Ports
//   clk_i        : clock, all logic on posedge
//   reset_n_i    : synchronous active-low reset
//   start_i      : run request, accepted in IDLE when abort_i is low
//   abort_i      : cancels a run in FILL or CHECK
//   chain_data_o : stimulus into the chain (0 outside FILL/CHECK)
//   chain_data_i : chain output
//   busy_o       : high in FILL and CHECK
//   done_o       : one-cycle pulse in DONE
//   pass_o       : result of the last completed run
//   err_count_o  : saturating mismatch count of the current/last run
//   state_o      : debug view of the FSM state (0 IDLE,1 FILL,2 CHECK,3 DONE)
//
// Handshake: start_i is a level sampled only in IDLE; a run is accepted on
// the edge where state is IDLE, start_i=1 and abort_i=0. done_o is a single
// cycle pulse; no further handshake is involved.

module delay_chain_tester #(
  parameter int width_p     = 2,
  parameter int depth_p     = 8,
  parameter int len_p       = 64,
  parameter int err_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic [width_p-1:0]     chain_data_o,
  input  logic [width_p-1:0]     chain_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [err_width_p-1:0] err_count_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int max_c = (depth_p > len_p) ? depth_p : len_p;
  localparam int cnt_w = $clog2(max_c) + 1;
  localparam logic [cnt_w-1:0] fill_last  = cnt_w'(depth_p - 1);
  localparam logic [cnt_w-1:0] check_last = cnt_w'(len_p - 1);
  localparam logic [err_width_p-1:0] err_max = '1;

`ifdef DELAY_CHAIN_TESTER_LFSR_EN
  localparam logic [15:0] gen_seed = 16'hACE1;
`else
  localparam logic [15:0] gen_seed = 16'h0000;
`endif

  // One generator step. Both the leading (drive) and lagging (compare)
  // generators use this, so they produce the identical sequence.
  function automatic logic [15:0] gen_next(input logic [15:0] s);
`ifdef DELAY_CHAIN_TESTER_LFSR_EN
    gen_next = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
`else
    gen_next = s + 16'd1;
`endif
  endfunction

  state_t           state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [15:0]      lead_q;
  logic [15:0]      lag_q;
  logic             start_accept;
  logic             running;
  logic             mismatch;
  logic             last_check;

  // Next-state and combinational outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_accept = 1'b0;
    running      = 1'b0;
    mismatch     = 1'b0;
    last_check   = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    chain_data_o = '0;

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          start_accept = 1'b1;
          state_d      = FILL;
          cnt_d        = '0;
        end
      end
      FILL: begin
        running      = 1'b1;
        busy_o       = 1'b1;
        chain_data_o = lead_q[width_p-1:0];
        cnt_d        = cnt_q + 1'b1;
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q == fill_last) begin
          state_d = CHECK;
          cnt_d   = '0;
        end
      end
      CHECK: begin
        running      = 1'b1;
        busy_o       = 1'b1;
        chain_data_o = lead_q[width_p-1:0];
        mismatch     = (chain_data_i != lag_q[width_p-1:0]);
        cnt_d        = cnt_q + 1'b1;
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q == check_last) begin
          last_check = 1'b1;
          state_d    = DONE;
          cnt_d      = '0;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

  // State, generators and result registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lead_q      <= gen_seed;
      lag_q       <= gen_seed;
      err_count_o <= '0;
      pass_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (start_accept) begin
        lead_q <= gen_seed;
        lag_q  <= gen_seed;
      end else begin
        if (running) lead_q <= gen_next(lead_q);
        if (state_q == CHECK) lag_q <= gen_next(lag_q);
      end

      // An aborted cycle's compare is discarded so the count holds.
      if (start_accept) begin
        err_count_o <= '0;
      end else if (mismatch && !abort_i && (err_count_o != err_max)) begin
        err_count_o <= err_count_o + 1'b1;
      end

      // Pass includes the final compare, which has not reached the counter.
      if (start_accept) begin
        pass_o <= 1'b0;
      end else if (running && abort_i) begin
        pass_o <= 1'b0;
      end else if (last_check) begin
        pass_o <= (err_count_o == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_delay_chain_tester.sv
module tb_delay_chain_tester;

  localparam int W = 4;
  localparam int D = 8;
  localparam int L = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n = 1'b0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [W-1:0] chain_data_o, chain_data_i;
  logic         busy_o, done_o, pass_o;
  logic [7:0]   err_count_o;
  logic [1:0]   state_o;

  logic [W-1:0] sat_data_o;
  logic         sat_busy, sat_done, sat_pass;
  logic [1:0]   sat_err;
  logic [1:0]   sat_state;

  delay_chain_tester #(.width_p(W), .depth_p(D), .len_p(L), .err_width_p(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_i), .abort_i(abort_i),
    .chain_data_o(chain_data_o), .chain_data_i(chain_data_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .state_o(state_o)
  );

  // Same stimulus, chain output stuck at zero, narrow saturating counter.
  delay_chain_tester #(.width_p(W), .depth_p(D), .len_p(L), .err_width_p(2)) u_sat (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_i), .abort_i(abort_i),
    .chain_data_o(sat_data_o), .chain_data_i(4'd0),
    .busy_o(sat_busy), .done_o(sat_done), .pass_o(sat_pass),
    .err_count_o(sat_err), .state_o(sat_state)
  );

  // ---------------- external chain model ----------------
  logic [W-1:0] pipe [0:7];
  int           chain_sel = 8;
  logic         flip_on = 1'b0;
  logic [W-1:0] flip_mask = '0;

  always_ff @(posedge clk) begin
    pipe[0] <= chain_data_o;
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end

  assign chain_data_i = ((chain_sel == 7) ? pipe[6] : pipe[7]) ^ (flip_on ? flip_mask : '0);

  // ---------------- reference pattern ----------------
  function automatic logic [W-1:0] pat(input int k);
`ifdef DELAY_CHAIN_TESTER_LFSR_EN
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    return s[W-1:0];
`else
    int m;
    m = k % (1 << W);
    return W'(m);
`endif
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [8:0]   done_q[$];
  logic [2:0]   sat_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy_o) begin
        if (exp_q.size() == 0) check("unexpected_busy", 1, 0);
        else check("chain_word", int'(chain_data_o), int'(exp_q.pop_front()));
      end else begin
        check("idle_chain_zero", int'(chain_data_o), 0);
      end
      if (done_o) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          logic [8:0] e;
          e = done_q.pop_front();
          check("done_pass", int'(pass_o), int'(e[8]));
          check("done_err", int'(err_count_o), int'(e[7:0]));
        end
      end
      if (sat_done) begin
        if (sat_q.size() == 0) check("unexpected_sat_done", 1, 0);
        else begin
          logic [2:0] e;
          e = sat_q.pop_front();
          check("sat_pass", int'(sat_pass), int'(e[2]));
          check("sat_err", int'(sat_err), int'(e[1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run. flip_j<0: no flip; abort_c=0: no abort, else abort during
  // busy cycle abort_c (1-based, cycle 1 is the first FILL cycle).
  task automatic run(input int chain_len, input int flip_j, input logic [W-1:0] mask,
                     input int abort_c);
    int exp_err, hold_err, sat_mis, n_words, c;
    bit seen;
    logic [W-1:0] got;
    exp_err = 0; hold_err = 0; sat_mis = 0;
    for (int j = 0; j < L; j++) begin
      got = pat(j + D - chain_len);
      if (j == flip_j) got = got ^ mask;
      if (got != pat(j)) begin
        exp_err++;
        if (D + 1 + j < abort_c) hold_err++;
      end
      if (pat(j) != '0) sat_mis++;
    end
    n_words = (abort_c > 0) ? abort_c : D + L;
    for (int k = 0; k < n_words; k++) exp_q.push_back(pat(k));
    if (abort_c == 0) begin
      done_q.push_back({(exp_err == 0), 8'((exp_err > 255) ? 255 : exp_err)});
      sat_q.push_back({(sat_mis == 0), 2'((sat_mis > 3) ? 3 : sat_mis)});
    end
    chain_sel = chain_len;
    flip_mask = mask;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("accept_busy", int'(busy_o), 1);
    check("accept_err_clear", int'(err_count_o), 0);
    check("accept_pass_clear", int'(pass_o), 0);
    c = 1;
    seen = 1'b0;
    while (c <= 40) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      flip_on = (flip_j >= 0) && (c == D + 1 + flip_j);
      abort_i = (c == abort_c);
      tick();
      if (abort_c > 0 && c == abort_c) begin
        abort_i = 1'b0;
        flip_on = 1'b0;
        check("abort_busy", int'(busy_o), 0);
        check("abort_done", int'(done_o), 0);
        check("abort_pass", int'(pass_o), 0);
        check("abort_err_hold", int'(err_count_o), hold_err);
        return;
      end
      c++;
    end
    flip_on = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
    end else begin
      check("run_latency", c, D + L + 1);
      tick();
      check("done_one_cycle", int'(done_o), 0);
      check("post_done_idle", int'(busy_o), 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy_o), 0);
    check("reset_done", int'(done_o), 0);
    check("reset_pass", int'(pass_o), 0);
    check("reset_err", int'(err_count_o), 0);
    check("reset_chain", int'(chain_data_o), 0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick();

    run(8, -1, '0, 0);                 // ideal chain
    check("pass_holds", int'(pass_o), 1);
    run(7, -1, '0, 0);                 // chain one stage short
    run(8, 5, 4'b0100, 0);             // single flipped bit in CHECK 5
    run(8, -1, '0, D + 1 + 3);         // abort in CHECK 3
    run(8, -1, '0, 0);                 // immediate fresh run

    // start ignored in IDLE while abort is high
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    check("start_blocked_by_abort", int'(busy_o), 0);

    // reset during FILL with start held high
    for (int k = 0; k < 4; k++) exp_q.push_back(pat(k));
    chain_sel = 8;
    start_i = 1'b1;
    tick();
    for (int c = 1; c < 4; c++) tick();
    reset_n = 1'b0;
    tick();
    check("midrun_reset_busy", int'(busy_o), 0);
    check("midrun_reset_done", int'(done_o), 0);
    check("midrun_reset_pass", int'(pass_o), 0);
    check("midrun_reset_err", int'(err_count_o), 0);
    check("midrun_reset_chain", int'(chain_data_o), 0);
    reset_n = 1'b1;
    start_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("no_queued_run", int'(busy_o), 0);
    end

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      int len, fj, ac;
      logic [W-1:0] m;
      len = int'($urandom_range(7, 8));
      fj  = int'($urandom_range(0, 3)) == 0 ? -1 : int'($urandom_range(0, L - 1));
      m   = W'(1 << $urandom_range(0, W - 1));
      ac  = int'($urandom_range(0, 2)) == 0 ? int'($urandom_range(1, D + L)) : 0;
      run(len, fj, m, ac);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("sat_q_drained", sat_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
